// File: rtl/acsi_pkg.sv
// acsi_pkg
// Shared definitions for the ACSI transfer sequencer: FSM state encoding,
// configuration-write target codes, control-byte bit positions and the
// SCSI-style status byte values returned in the status phase.
package acsi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_STATUS  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // cfg_sel write targets
    localparam logic [1:0] SEL_CNT_LO = 2'd0;
    localparam logic [1:0] SEL_CNT_HI = 2'd1;
    localparam logic [1:0] SEL_CTRL   = 2'd2;
    localparam logic [1:0] SEL_STATUS = 2'd3;

    // control byte bit indices
    localparam int CTL_DIR     = 0;
    localparam int CTL_START   = 1;
    localparam int CTL_ABORT   = 2;
    localparam int CTL_IRQ_CLR = 3;

    // status byte values
    localparam logic [7:0] STATUS_GOOD  = 8'h00;
    localparam logic [7:0] STATUS_CHECK = 8'h02;

endpackage

// File: rtl/acsi_byte_counter.sv
// acsi_byte_counter
// Byte-in-block counter plus remaining-block down-counter.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   load_lo/hi     load low/high byte of the block count from load_data
//   load_data      byte to load
//   count_en       one data byte completed
//   clear          zero the byte-in-block counter (abort / new sequence)
//   blocks_left    remaining whole blocks
//   last_byte      the next counted byte completes the final block
module acsi_byte_counter
    import acsi_pkg::*;
#(
    parameter int BLOCK_BYTES = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [7:0]  load_data,
    input  logic        count_en,
    input  logic        clear,
    output logic [15:0] blocks_left,
    output logic        last_byte
);

    localparam int CNT_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK_BYTES - 1);

    logic [CNT_W-1:0] byte_cnt;
    logic             wrap;

    assign wrap      = count_en && (byte_cnt == CNT_MAX);
    assign last_byte = (byte_cnt == CNT_MAX) && (blocks_left == 16'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt    <= '0;
            blocks_left <= '0;
        end else begin
            // A strobe coinciding with clear still retires its block below,
            // but the byte position restarts from zero.
            if (clear)
                byte_cnt <= '0;
            else if (count_en)
                byte_cnt <= wrap ? '0 : byte_cnt + 1'b1;

            if (load_lo)
                blocks_left[7:0] <= load_data;
            if (load_hi)
                blocks_left[15:8] <= load_data;
            if (wrap && (blocks_left != 16'd0))
                blocks_left <= blocks_left - 16'd1;
        end
    end

endmodule

// File: rtl/acsi_xfer_sequencer.sv
// acsi_xfer_sequencer
// Walks the ACSI bridge through data phase, status phase and deselect so
// the AVR only programs count/direction/status and issues a start.
// Optional feature macro: ACSI_XFER_TIMEOUT_EN (data-phase idle watchdog).
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   cfg_we/sel/data     AVR configuration write (count lo/hi, control, status)
//   xfer_strobe         one data byte completed on ACSI
//   status_strobe       Atari read the status byte
//   data_mode           1 = bridge data mode, 0 = command mode
//   xfer_dir            latched direction (1 = device to Atari)
//   status_valid        status byte presented
//   status_byte         status returned to the Atari
//   deselect            one-cycle forced-unselect pulse
//   busy                sequence in progress
//   done_irq, err       sticky completion / error flags
//   blocks_left         remaining block count
module acsi_xfer_sequencer
    import acsi_pkg::*;
#(
    parameter int BLOCK_BYTES    = 512,
    parameter int TIMEOUT_CYCLES = 16777215
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_sel,
    input  logic [7:0]  cfg_data,
    input  logic        xfer_strobe,
    input  logic        status_strobe,
    output logic        data_mode,
    output logic        xfer_dir,
    output logic        status_valid,
    output logic [7:0]  status_byte,
    output logic        deselect,
    output logic        busy,
    output logic        done_irq,
    output logic        err,
    output logic [15:0] blocks_left
);

    state_t state, state_nxt;

    logic ctl_wr, is_idle, start_idle, start_busy;
    logic abort_wr, abort_fire, timeout_fire, count_en, last_byte;

    assign is_idle    = (state == ST_IDLE);
    assign ctl_wr     = cfg_we && (cfg_sel == SEL_CTRL);
    assign start_idle = ctl_wr && cfg_data[CTL_START] && is_idle;
    assign start_busy = ctl_wr && cfg_data[CTL_START] && !is_idle;
    assign abort_wr   = ctl_wr && cfg_data[CTL_ABORT] &&
                        ((state == ST_DATA) || (state == ST_STATUS));
    assign abort_fire = abort_wr || timeout_fire;
    assign count_en   = xfer_strobe && (state == ST_DATA);

    acsi_byte_counter #(
        .BLOCK_BYTES (BLOCK_BYTES)
    ) u_byte_counter (
        .clock       (clock),
        .reset       (reset),
        .load_lo     (cfg_we && (cfg_sel == SEL_CNT_LO) && is_idle),
        .load_hi     (cfg_we && (cfg_sel == SEL_CNT_HI) && is_idle),
        .load_data   (cfg_data),
        .count_en    (count_en),
        .clear       (abort_fire || start_idle),
        .blocks_left (blocks_left),
        .last_byte   (last_byte)
    );

`ifdef ACSI_XFER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    assign timeout_fire = (state == ST_DATA) && !xfer_strobe && (wd_cnt == WD_LAST);

    always_ff @(posedge clock) begin
        if (reset)
            wd_cnt <= '0;
        else if (start_idle || xfer_strobe)
            wd_cnt <= '0;
        else if (state == ST_DATA)
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign timeout_fire   = 1'b0;
`endif

    // state register
    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (start_idle)
                    state_nxt = (blocks_left == 16'd0) ? ST_STATUS : ST_DATA;
            ST_DATA:
                if (abort_fire || (count_en && last_byte))
                    state_nxt = ST_STATUS;
            ST_STATUS:
                if (!abort_wr && status_strobe)
                    state_nxt = ST_RELEASE;
            ST_RELEASE:
                state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    // output decode from the state register only
    always_comb begin
        data_mode    = (state == ST_DATA);
        status_valid = (state == ST_STATUS);
        deselect     = (state == ST_RELEASE);
        busy         = (state != ST_IDLE);
    end

    // sticky flags, direction and status byte
    always_ff @(posedge clock) begin
        if (reset) begin
            xfer_dir    <= 1'b0;
            status_byte <= STATUS_GOOD;
            done_irq    <= 1'b0;
            err         <= 1'b0;
        end else begin
            // clear first so a set in the same cycle survives
            if (ctl_wr && cfg_data[CTL_IRQ_CLR]) begin
                done_irq <= 1'b0;
                err      <= 1'b0;
            end
            if (start_busy || timeout_fire)
                err <= 1'b1;
            if ((state == ST_STATUS) && status_strobe && !abort_wr)
                done_irq <= 1'b1;
            if (start_idle)
                xfer_dir <= cfg_data[CTL_DIR];
            if (cfg_we && (cfg_sel == SEL_STATUS) && is_idle)
                status_byte <= cfg_data;
            if (abort_fire)
                status_byte <= STATUS_CHECK;
        end
    end

endmodule

// File: tb/tb_acsi_xfer_sequencer.sv
module tb_acsi_xfer_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_sel = 2'd0;
    logic [7:0]  cfg_data = 8'h00;
    logic        xfer_strobe = 1'b0;
    logic        status_strobe = 1'b0;
    logic        data_mode, xfer_dir, status_valid, deselect, busy, done_irq, err;
    logic [7:0]  status_byte;
    logic [15:0] blocks_left;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    acsi_xfer_sequencer #(
        .BLOCK_BYTES    (512),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cfg_we        (cfg_we),
        .cfg_sel       (cfg_sel),
        .cfg_data      (cfg_data),
        .xfer_strobe   (xfer_strobe),
        .status_strobe (status_strobe),
        .data_mode     (data_mode),
        .xfer_dir      (xfer_dir),
        .status_valid  (status_valid),
        .status_byte   (status_byte),
        .deselect      (deselect),
        .busy          (busy),
        .done_irq      (done_irq),
        .err           (err),
        .blocks_left   (blocks_left)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // advance one clock; outputs are stable 1ns after the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [7:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
        tick();
        cfg_we = 1'b0; cfg_data = 8'h00;
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            xfer_strobe = 1'b1;
            tick();
        end
        xfer_strobe = 1'b0;
    endtask

    task automatic status_read();
        status_strobe = 1'b1;
        tick();
        status_strobe = 1'b0;
    endtask

    initial begin
        // reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_data_mode", data_mode, 0);
        chk("rst_status_valid", status_valid, 0);
        chk("rst_deselect", deselect, 0);
        chk("rst_done", done_irq, 0);
        chk("rst_err", err, 0);
        chk("rst_dir", xfer_dir, 0);
        chk("rst_status_byte", status_byte, 8'h00);
        chk("rst_blocks", blocks_left, 16'h0000);

        // high count byte loads upper half
        cfg_write(2'd1, 8'h01);
        chk("cnt_hi_load", blocks_left, 16'h0100);

        // one block, dir=1
        cfg_write(2'd0, 8'h01);
        cfg_write(2'd1, 8'h00);
        cfg_write(2'd3, 8'h55);
        cfg_write(2'd2, 8'h03);
        chk("t1_busy", busy, 1);
        chk("t1_data_mode", data_mode, 1);
        chk("t1_dir", xfer_dir, 1);
        chk("t1_blocks", blocks_left, 16'd1);
        strobes(511);
        chk("t1_511_data_mode", data_mode, 1);
        chk("t1_511_blocks", blocks_left, 16'd1);
        strobes(1);
        chk("t1_end_data_mode", data_mode, 0);
        chk("t1_end_status_valid", status_valid, 1);
        chk("t1_end_blocks", blocks_left, 16'd0);
        chk("t1_status_byte", status_byte, 8'h55);
        status_read();
        chk("t1_deselect", deselect, 1);
        chk("t1_done_rise", done_irq, 1);
        tick();
        chk("t1_deselect_low", deselect, 0);
        chk("t1_idle", busy, 0);
        cfg_write(2'd2, 8'h08);
        chk("t1_irq_clr", done_irq, 0);

        // three blocks, dir=0
        cfg_write(2'd0, 8'h03);
        cfg_write(2'd3, 8'h00);
        cfg_write(2'd2, 8'h02);
        chk("t2_dir", xfer_dir, 0);
        strobes(1535);
        chk("t2_1535_data_mode", data_mode, 1);
        chk("t2_1535_blocks", blocks_left, 16'd1);
        strobes(1);
        chk("t2_end_status_valid", status_valid, 1);
        chk("t2_end_blocks", blocks_left, 16'd0);
        strobes(1);
        chk("t2_strobe_in_status", status_valid, 1);
        status_read();
        tick();
        chk("t2_idle", busy, 0);
        cfg_write(2'd2, 8'h08);

        // zero count goes straight to status
        cfg_write(2'd0, 8'h00);
        cfg_write(2'd2, 8'h02);
        chk("t3_busy", busy, 1);
        chk("t3_status_valid", status_valid, 1);
        chk("t3_data_mode", data_mode, 0);
        status_read();
        chk("t3_deselect", deselect, 1);
        chk("t3_done", done_irq, 1);
        tick();
        chk("t3_deselect_low", deselect, 0);
        chk("t3_done_sticky", done_irq, 1);
        cfg_write(2'd2, 8'h08);
        chk("t3_irq_clr", done_irq, 0);

        // abort mid-data, then start while busy
        cfg_write(2'd0, 8'h02);
        cfg_write(2'd2, 8'h02);
        strobes(100);
        cfg_write(2'd2, 8'h04);
        chk("t4_abort_status_valid", status_valid, 1);
        chk("t4_abort_byte", status_byte, 8'h02);
        chk("t4_abort_blocks", blocks_left, 16'd2);
        cfg_write(2'd2, 8'h02);
        chk("t4_err", err, 1);
        chk("t4_state_kept", status_valid, 1);
        cfg_write(2'd0, 8'h07);
        chk("t4_cnt_write_busy", blocks_left, 16'd2);
        status_read();
        tick();
        cfg_write(2'd2, 8'h08);
        chk("t4_err_clr", err, 0);

        // abort coinciding with final strobe
        cfg_write(2'd0, 8'h01);
        cfg_write(2'd3, 8'h00);
        cfg_write(2'd2, 8'h02);
        strobes(511);
        xfer_strobe = 1'b1;
        cfg_write(2'd2, 8'h04);
        xfer_strobe = 1'b0;
        chk("t5_status_valid", status_valid, 1);
        chk("t5_byte", status_byte, 8'h02);
        chk("t5_blocks", blocks_left, 16'd0);
        status_read();
        tick();
        cfg_write(2'd2, 8'h08);

        // reset in the middle of data phase
        cfg_write(2'd0, 8'h02);
        cfg_write(2'd3, 8'h77);
        cfg_write(2'd2, 8'h03);
        strobes(10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_data_mode", data_mode, 0);
        chk("t6_deselect", deselect, 0);
        chk("t6_dir", xfer_dir, 0);
        chk("t6_status_byte", status_byte, 8'h00);
        chk("t6_blocks", blocks_left, 16'd0);
        tick();
        chk("t6_no_deselect", deselect, 0);

`ifdef ACSI_XFER_TIMEOUT_EN
        // watchdog: 50 idle data-phase cycles act as an abort
        cfg_write(2'd0, 8'h01);
        cfg_write(2'd2, 8'h02);
        for (int i = 0; i < 49; i++) tick();
        chk("t7_still_data", data_mode, 1);
        tick();
        chk("t7_status_valid", status_valid, 1);
        chk("t7_byte", status_byte, 8'h02);
        chk("t7_err", err, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
